de2_115_sd_card_nios_from_hw_port: RTL

Avalon-MM slave input port. Nios II software uses it to sample a 16-bit hardware status bus (in_port). It is the hardware-to-CPU counterpart of the existing CPU-to-hardware output port.
- Synchronises the asynchronous input and detects edges per bit.
- Latches detected edges in an edge-capture register.
- Raises a maskable, level-sensitive interrupt.
It sits on the same system interconnect as the other PIO slaves.

---
 rtl/de2_115_sd_card_nios_from_hw_port.sv | 85 ++++++++
 1 files changed

// File: rtl/de2_115_sd_card_nios_from_hw_port.sv
// Avalon-MM PIO input port: synchronised status bus, per-bit edge
// capture with write-1-to-clear, and a maskable level interrupt.
module de2_115_sd_card_nios_from_hw_port #(
  parameter int WIDTH       = 16,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] clr;
  logic             rd_en;
  logic             wr_en;
  logic [31:0]      rd_mux;
  logic             unused_wd;

  assign sync_in   = sync_q[SYNC_STAGES-1];
  assign rd_en     = chipselect && write_n;
  assign wr_en     = chipselect && !write_n;
  assign rise      = sync_in & ~prev;
  assign fall      = ~sync_in & prev;
  assign unused_wd = ^writedata;

  always_comb begin
    edge_det = rise | fall;
    if (EDGE_TYPE == 0)
      edge_det = rise;
    else if (EDGE_TYPE == 1)
      edge_det = fall;
  end

  always_comb begin
    clr = '0;
    if (wr_en && address == 2'd3)
      clr = writedata[WIDTH-1:0];
  end

  always_comb begin
    rd_mux = '0;
    unique case (address)
      2'd0:    rd_mux = 32'(sync_in);
      2'd2:    rd_mux = 32'(irqmask);
      2'd3:    rd_mux = 32'(edgecapture);
      default: rd_mux = '0;
    endcase
  end

  // irq looks at the registered capture, so it trails a new capture by one cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= '0;
      prev        <= '0;
      irqmask     <= '0;
      edgecapture <= '0;
      readdata    <= '0;
      irq         <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], in_port};
      prev        <= sync_in;
      edgecapture <= edge_det | (edgecapture & ~clr);
      irq         <= |(edgecapture & irqmask);
      if (wr_en && address == 2'd2)
        irqmask <= writedata[WIDTH-1:0];
      if (rd_en)
        readdata <= rd_mux;
    end
  end

endmodule
